tdoa_peak_search: RTL and testbench
===================================

// Module: tdoa_peak_search
// PURPOSE
//  Upstream feeder of the position solver. Consumes the cross-correlation stream for the 6 mic
//  pairs, finds the lag of the correlation peak for each pair, then publishes 6 signed lags with
//  a one-cycle ena pulse. Holds off the next publish until the solver reports pos_done.
// PARAMETERS
//  CORR_W   32  width of signed correlation sample
//  LAG_W    6   width of signed lag output; must hold +/-MAX_LAG
//  MAX_LAG  20  lags scanned per pair: -MAX_LAG..+MAX_LAG (2*MAX_LAG+1 samples), MAX_LAG<=2^(LAG_W-1)-1
//  PAIRS    6   mic pairs per frame (fixed 6; outputs are enumerated)
// PORTS
//  clk            in   1       system clock
//  rst_n          in   1       asynchronous active-low reset
//  corr_valid     in   1       corr_data valid this cycle
//  corr_sof       in   1       with corr_valid: first sample of frame (pair 0, lag -MAX_LAG)
//  corr_data      in   CORR_W  signed correlation value
//  pos_done       in   1       solver finished; clk-domain level or pulse
//  lag_diff_out_0..5 out LAG_W signed peak lag for pair 0..5
//  ena            out  1       one-cycle pulse: lag_diff_out_* valid
//  busy           out  1       high in SCAN, PUBLISH, WAIT_DONE
//  frame_err      out  1       one-cycle pulse: sof seen mid-scan
//  frame_drop     out  1       one-cycle pulse: frame sof arrived during WAIT_DONE (frame ignored)
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, lag_cnt=-MAX_LAG, pair_cnt=0, running max/argmax cleared.
//  Sample order per frame: pair 0 lags -MAX_LAG..+MAX_LAG, then pair 1 ... pair 5; 6*(2*MAX_LAG+1)
//   accepted samples. Samples accepted only when corr_valid=1; gaps of any length allowed.
//  FSM:
//   IDLE: valid&sof -> SCAN, sample taken as pair0/lag -MAX_LAG. valid without sof ignored.
//   SCAN: each accepted sample: lag_cnt++; wraps to -MAX_LAG and pair_cnt++ after +MAX_LAG.
//    Per pair, first sample loads max/argmax; later sample replaces only if strictly greater
//    (signed compare) -> ties keep the most negative lag. At pair end argmax is stored to pair slot.
//    Last sample (pair 5, lag +MAX_LAG) -> PUBLISH.
//    valid&sof mid-scan: frame_err pulse next cycle, scan restarts with this sample as pair0/-MAX_LAG;
//    partially found lags discarded, outputs unchanged.
//   PUBLISH: lag_diff_out_0..5 updated from stored slots and ena=1 for exactly one cycle;
//    latency: last sample accepted at cycle N -> outputs+ena at cycle N+1. -> WAIT_DONE.
//    pos_done ignored in PUBLISH.
//   WAIT_DONE: pos_done=1 -> IDLE (next cycle). valid&sof -> frame_drop pulse, samples of that frame
//    ignored; a sof coinciding with pos_done is also dropped (no mid-frame resync).
//  lag_diff_out_* hold between ena pulses; never change outside PUBLISH.
//  Lag arithmetic: lag_cnt LAG_W-bit signed, no overflow for legal MAX_LAG.
//  Reset mid-operation: immediate return to reset values; no ena issued for an incomplete frame.
// TESTING
//  1 MAX_LAG=20, frame with single peak 1000 at lags {-3,0,5,-20,20,7} -> one ena, outputs exactly those.
//  2 Pair 2 equal peaks 500 at lags -4 and +6 -> lag_diff_out_2=-4.
//  3 Random valid gaps (~50% duty) on test 1 data -> identical outputs; ena 1 cycle after last sample.
//  4 sof injected at pair 3 lag 0, then full frame -> frame_err once, single ena with second frame's lags.
//  5 Second frame while pos_done low -> frame_drop once, no ena; pos_done then new frame -> new ena.
//  6 rst_n low mid-scan pair 4 -> outputs 0, busy 0; following full frame publishes correctly.

Source files
------------

// File: rtl/tdoa_peak_search.sv
// rtl/tdoa_peak_search.sv - per-pair correlation peak lag search feeding the position solver
// Scans 6 pairs x (2*MAX_LAG+1) samples, publishes the argmax lag of each pair with a one-cycle ena.
module tdoa_peak_search #(
  parameter int CORR_W  = 32,
  parameter int LAG_W   = 6,
  parameter int MAX_LAG = 20,
  parameter int PAIRS   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              corr_valid,
  input  logic              corr_sof,
  input  logic [CORR_W-1:0] corr_data,
  input  logic              pos_done,
  output logic [LAG_W-1:0]  lag_diff_out_0,
  output logic [LAG_W-1:0]  lag_diff_out_1,
  output logic [LAG_W-1:0]  lag_diff_out_2,
  output logic [LAG_W-1:0]  lag_diff_out_3,
  output logic [LAG_W-1:0]  lag_diff_out_4,
  output logic [LAG_W-1:0]  lag_diff_out_5,
  output logic              ena,
  output logic              busy,
  output logic              frame_err,
  output logic              frame_drop
);

  typedef enum logic [1:0] {IDLE, SCAN, PUBLISH, WAIT_DONE} state_t;

  localparam logic signed [LAG_W-1:0] LAG_LO    = LAG_W'(-MAX_LAG);
  localparam logic signed [LAG_W-1:0] LAG_HI    = LAG_W'(MAX_LAG);
  localparam logic        [2:0]       LAST_PAIR = 3'(PAIRS - 1);

  state_t                    state, state_nxt;
  logic signed [LAG_W-1:0]   lag_cnt, arg_max;
  logic        [2:0]         pair_cnt;
  logic signed [CORR_W-1:0]  max_val;
  logic        [LAG_W-1:0]   slot [0:PAIRS-1];

  logic                      take, upd, pair_end, frame_end;
  logic signed [LAG_W-1:0]   cur_lag, arg_nxt;
  logic        [2:0]         cur_pair;
  logic signed [CORR_W-1:0]  max_nxt;

  // A sof sample always restarts at pair 0 / lowest lag, regardless of the counters.
  always_comb begin
    take      = corr_valid && ((state == IDLE && corr_sof) || state == SCAN);
    cur_lag   = corr_sof ? LAG_LO : lag_cnt;
    cur_pair  = corr_sof ? 3'd0 : pair_cnt;
    upd       = (cur_lag == LAG_LO) || ($signed(corr_data) > max_val);
    max_nxt   = upd ? $signed(corr_data) : max_val;
    arg_nxt   = upd ? cur_lag : arg_max;
    pair_end  = (cur_lag == LAG_HI);
    frame_end = take && pair_end && (cur_pair == LAST_PAIR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (corr_valid && corr_sof) state_nxt = SCAN;
      SCAN:      if (frame_end) state_nxt = PUBLISH;
      PUBLISH:   state_nxt = WAIT_DONE;
      WAIT_DONE: if (pos_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lag_cnt        <= LAG_LO;
      pair_cnt       <= 3'd0;
      max_val        <= '0;
      arg_max        <= '0;
      for (int i = 0; i < PAIRS; i++) slot[i] <= '0;
      lag_diff_out_0 <= '0;
      lag_diff_out_1 <= '0;
      lag_diff_out_2 <= '0;
      lag_diff_out_3 <= '0;
      lag_diff_out_4 <= '0;
      lag_diff_out_5 <= '0;
      ena            <= 1'b0;
      frame_err      <= 1'b0;
      frame_drop     <= 1'b0;
    end else begin
      ena        <= 1'b0;
      frame_err  <= 1'b0;
      frame_drop <= 1'b0;
      if (take) begin
        max_val <= max_nxt;
        arg_max <= arg_nxt;
        if (pair_end) begin
          lag_cnt        <= LAG_LO;
          slot[cur_pair] <= arg_nxt;
          pair_cnt       <= (cur_pair == LAST_PAIR) ? 3'd0 : cur_pair + 3'd1;
        end else begin
          lag_cnt  <= cur_lag + LAG_W'(1);
          pair_cnt <= cur_pair;
        end
        // The last pair's winner is still combinational here, so it bypasses its slot.
        if (frame_end) begin
          lag_diff_out_0 <= slot[0];
          lag_diff_out_1 <= slot[1];
          lag_diff_out_2 <= slot[2];
          lag_diff_out_3 <= slot[3];
          lag_diff_out_4 <= slot[4];
          lag_diff_out_5 <= arg_nxt;
          ena            <= 1'b1;
        end
      end
      if (state == SCAN && corr_valid && corr_sof)      frame_err  <= 1'b1;
      if (state == WAIT_DONE && corr_valid && corr_sof) frame_drop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdoa_peak_search.sv
// tb/tb_tdoa_peak_search.sv - scoreboard bench for tdoa_peak_search
// Stimulus pushes expected lag sets; a negedge monitor pops and compares on each ena.
module tb_tdoa_peak_search;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        corr_valid, corr_sof, pos_done;
  logic [31:0] corr_data;
  logic [5:0]  lag0, lag1, lag2, lag3, lag4, lag5;
  logic        ena, busy, frame_err, frame_drop;

  tdoa_peak_search #(.CORR_W(32), .LAG_W(6), .MAX_LAG(20), .PAIRS(6)) dut (
    .clk(clk), .rst_n(rst_n),
    .corr_valid(corr_valid), .corr_sof(corr_sof), .corr_data(corr_data),
    .pos_done(pos_done),
    .lag_diff_out_0(lag0), .lag_diff_out_1(lag1), .lag_diff_out_2(lag2),
    .lag_diff_out_3(lag3), .lag_diff_out_4(lag4), .lag_diff_out_5(lag5),
    .ena(ena), .busy(busy), .frame_err(frame_err), .frame_drop(frame_drop)
  );

  always #5 clk = ~clk;

  typedef int lag6_t [6];
  typedef struct packed {
    logic [35:0] lags;
    int          cyc;
  } exp_t;

  exp_t exp_q [$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   err_cnt = 0;
  int   drop_cnt = 0;
  int   ena_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lag_of(input logic [35:0] v, input int p);
    logic [5:0] s;
    s = v[p*6 +: 6];
    return int'($signed(s));
  endfunction

  always @(negedge clk) begin
    logic [35:0] got;
    exp_t        e;
    if (rst_n) begin
      if (frame_err)  err_cnt++;
      if (frame_drop) drop_cnt++;
      if (ena) begin
        ena_cnt++;
        if (exp_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_ena: got ena at cycle %0d expected none", cyc);
        end else begin
          e   = exp_q.pop_front();
          got = {lag5, lag4, lag3, lag2, lag1, lag0};
          check("ena_cycle", cyc, e.cyc);
          for (int p = 0; p < 6; p++)
            check($sformatf("lag_pair%0d", p), lag_of(got, p), lag_of(e.lags, p));
        end
      end
    end
  end

  // Drives one frame; stop_pair >= 0 aborts before (stop_pair, lag 0) to model a truncated frame.
  task automatic drive_frame(input lag6_t pk, input lag6_t pk2, input int amp, input bit gaps,
                             input int stop_pair, input bit push, input lag6_t exp);
    exp_t e;
    bit   stop;
    stop = 1'b0;
    for (int p = 0; p < 6 && !stop; p++) begin
      for (int l = -20; l <= 20; l++) begin
        if (p == stop_pair && l == 0) begin
          stop = 1'b1;
          break;
        end
        if (gaps) begin
          repeat ($urandom_range(0, 1)) begin
            @(negedge clk);
            corr_valid = 1'b0;
            corr_sof   = 1'b0;
            corr_data  = 32'hDEAD_BEEF;
          end
        end
        @(negedge clk);
        corr_valid = 1'b1;
        corr_sof   = (p == 0 && l == -20);
        corr_data  = (l == pk[p] || l == pk2[p]) ? amp : (p * 10 + (l + 20) * 2);
        if (push && p == 5 && l == 20) begin
          for (int q = 0; q < 6; q++) e.lags[q*6 +: 6] = 6'(exp[q]);
          e.cyc = cyc + 1;
          exp_q.push_back(e);
        end
      end
    end
    @(negedge clk);
    corr_valid = 1'b0;
    corr_sof   = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: got %0d pending expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic pulse_done();
    @(negedge clk);
    pos_done = 1'b1;
    @(negedge clk);
    pos_done = 1'b0;
    check("busy_after_done", int'(busy), 0);
  endtask

  task automatic check_zero_outputs(input string name);
    check({name, "_lag0"}, int'(lag0), 0);
    check({name, "_lag5"}, int'(lag5), 0);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_ena"},  int'(ena),  0);
  endtask

  lag6_t none = '{99, 99, 99, 99, 99, 99};
  lag6_t t1   = '{-3, 0, 5, -20, 20, 7};
  lag6_t t2   = '{1, 2, -4, 3, 4, 5};
  lag6_t t2b  = '{99, 99, 6, 99, 99, 99};
  lag6_t t4a  = '{-5, -5, -5, -5, -5, -5};
  lag6_t t4   = '{10, -10, 2, -2, 15, -15};
  lag6_t t5   = '{-1, 1, -2, 2, -3, 3};

  initial begin
    rst_n = 1'b0; corr_valid = 1'b0; corr_sof = 1'b0; corr_data = '0; pos_done = 1'b0;
    repeat (3) @(negedge clk);
    check_zero_outputs("reset");
    check("reset_frame_err", int'(frame_err), 0);
    rst_n = 1'b1;

    drive_frame(t1, none, 1000, 1'b0, -1, 1'b1, t1);
    wait_empty("t1");
    check("busy_wait_done", int'(busy), 1);
    pulse_done();

    drive_frame(t2, t2b, 500, 1'b0, -1, 1'b1, t2);
    wait_empty("t2");
    pulse_done();

    drive_frame(t1, none, 1000, 1'b1, -1, 1'b1, t1);
    wait_empty("t3");
    pulse_done();

    drive_frame(t4a, none, 1000, 1'b0, 3, 1'b0, none);
    drive_frame(t4, none, 1000, 1'b1, -1, 1'b1, t4);
    wait_empty("t4");
    check("frame_err_count", err_cnt, 1);

    drive_frame(t1, none, 1000, 1'b0, -1, 1'b0, none);
    repeat (5) @(negedge clk);
    check("frame_drop_count", drop_cnt, 1);
    check("held_lag0_after_drop", lag_of({lag5, lag4, lag3, lag2, lag1, lag0}, 0), 10);
    pulse_done();
    drive_frame(t5, none, 1000, 1'b0, -1, 1'b1, t5);
    wait_empty("t5");
    pulse_done();

    drive_frame(t1, none, 1000, 1'b0, 4, 1'b0, none);
    check("busy_mid_scan", int'(busy), 1);
    rst_n = 1'b0;
    @(negedge clk);
    check_zero_outputs("midscan_reset");
    rst_n = 1'b1;
    drive_frame(t1, none, 1000, 1'b0, -1, 1'b1, t1);
    wait_empty("t6");
    pulse_done();

    check("total_ena", ena_cnt, 6);
    check("final_frame_err_count", err_cnt, 1);
    check("final_frame_drop_count", drop_cnt, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
